// File: rtl/instr_block_memory.sv
// Line-organised instruction/data store: byte-lane write port, combinational read, per-line valid, refill sequencer.
// Latency: reads are 0 cycles (combinational); writes and fill beats land on the rising edge; fill_done pulses the cycle after the last beat.
// Backpressure: the fill port has none; the sequencer simply waits through fill_valid gaps, and access writes to the line being filled are dropped.
module instr_block_memory #(
  parameter int lines     = 16,
  parameter int blocksize = 4,
  parameter int setbits   = $clog2(lines),
  parameter int wordbits  = $clog2(blocksize)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                we,
  input  logic [3:0]          be,
  input  logic [31:0]         wd,
  input  logic [setbits-1:0]  set,
  input  logic [wordbits-1:0] word,
  output logic [31:0]         rd,
  output logic                valid,
  input  logic                fill_start,
  input  logic [setbits-1:0]  fill_set,
  input  logic                fill_valid,
  input  logic [31:0]         fill_wd,
  output logic                fill_busy,
  output logic                fill_done
);

  typedef enum logic {IDLE, FILL} state_t;

  state_t              state;
  logic [setbits-1:0]  fset;
  logic [wordbits-1:0] cnt;
  logic [lines-1:0]    vbit;

  // Four independent byte lanes so a partial write touches only its enabled bytes.
  logic [7:0] lane [4][lines][blocksize];

  logic fill_accept;
  logic fill_beat;
  logic last_beat;
  logic acc_drop;
  logic acc_wr;

  // A fill_start only counts when the sequencer is idle; one arriving mid-fill is ignored.
  assign fill_accept = (state == IDLE) && fill_start;
  assign fill_beat   = (state == FILL) && fill_valid;
  assign last_beat   = fill_beat && (cnt == wordbits'(blocksize - 1));

  // Access writes must not race the refill: the line in flight, or the line being
  // claimed this very edge, is off-limits to the processor.
  assign acc_drop = ((state == FILL) && (set == fset)) || (fill_accept && (set == fill_set));
  assign acc_wr   = we && !acc_drop;

  assign rd        = {lane[3][set][word], lane[2][set][word], lane[1][set][word], lane[0][set][word]};
  assign valid     = vbit[set];
  assign fill_busy = (state == FILL);

  // Data array update: access-port byte writes and full-word refill beats (never the same line).
  always_ff @(posedge clk) begin
    for (int l = 0; l < 4; l++) begin
      if (acc_wr && be[l]) begin
        lane[l][set][word] <= wd[8*l +: 8];
      end
      if (fill_beat) begin
        lane[l][fset][cnt] <= fill_wd[8*l +: 8];
      end
    end
  end

  // Refill sequencer: latches the target line, counts beats, pulses fill_done after the last one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      fset      <= '0;
      cnt       <= '0;
      fill_done <= 1'b0;
    end else begin
      fill_done <= last_beat;
      case (state)
        IDLE: begin
          if (fill_start) begin
            fset  <= fill_set;
            cnt   <= '0;
            state <= FILL;
          end
        end
        FILL: begin
          if (fill_valid) begin
            cnt <= cnt + wordbits'(1);
            if (last_beat) begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Line valid bits: invalidated when a refill claims the line, set once its last word lands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vbit <= '0;
    end else if (fill_accept) begin
      vbit[fill_set] <= 1'b0;
    end else if (last_beat) begin
      vbit[fset] <= 1'b1;
    end
  end

endmodule
